// File: rtl/trid_burst_drain.sv
// -----------------------------------------------------------------------------
// trid_burst_drain
//
// Burst drain stage placed after the 16-entry transaction-ID priority encoder.
// When any slot has a head beat available, the encoder's selected slot is
// latched as the grant. That slot's response burst is then streamed, beat by
// beat, onto one valid/ready output. Each accepted beat pops the slot's
// response buffer. The grant is only released after the last beat, so bursts
// from different IDs never interleave. A burst that reaches MAX_BEATS without
// a natural last beat is cut off, and a sticky error flag is raised.
//
// Ports:
//   i_clk        clock
//   i_rstn       asynchronous active-low reset
//   i_ready      per-slot head beat available, MSB-first (bit TRIDNUM-1-s = slot s)
//   i_sel        encoder choice: highest-priority ready slot (slot 0 highest)
//   i_data       head beat of slot s at i_data[s*DATA_W +: DATA_W]
//   i_last       i_last[s]: slot s's head beat ends its burst
//   o_pop        one-hot pop of the granted slot's head beat (LSB-first)
//   o_valid      output beat valid
//   i_out_ready  downstream accepts the beat
//   o_data       output beat
//   o_tid        slot ID of the current beat
//   o_last       final beat of the burst (natural or forced)
//   o_busy       grant held
//   o_err        sticky: a burst was force-terminated at MAX_BEATS
// -----------------------------------------------------------------------------
module trid_burst_drain #(
   parameter int TRIDNUM   = 16,
   parameter int TRIDBIT   = 4,
   parameter int DATA_W    = 64,
   parameter int MAX_BEATS = 256
) (
   input  logic                      i_clk,
   input  logic                      i_rstn,
   input  logic [TRIDNUM-1:0]        i_ready,
   input  logic [TRIDBIT-1:0]        i_sel,
   input  logic [TRIDNUM*DATA_W-1:0] i_data,
   input  logic [TRIDNUM-1:0]        i_last,
   output logic [TRIDNUM-1:0]        o_pop,
   output logic                      o_valid,
   input  logic                      i_out_ready,
   output logic [DATA_W-1:0]         o_data,
   output logic [TRIDBIT-1:0]        o_tid,
   output logic                      o_last,
   output logic                      o_busy,
   output logic                      o_err
);

   localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t             state;
   logic [TRIDBIT-1:0] grant;
   logic [CNT_W-1:0]   count;
   logic               err;

   // Per-slot views of the packed inputs. i_ready arrives MSB-first, so it is
   // flipped here once; everything downstream indexes slots LSB-first.
   logic [TRIDNUM-1:0] ready_slot;
   logic [DATA_W-1:0]  data_slot [TRIDNUM];

   always_comb begin
      for (int s = 0; s < TRIDNUM; s++) begin
         ready_slot[s] = i_ready[TRIDNUM-1-s];
         data_slot[s]  = i_data[s*DATA_W +: DATA_W];
      end
   end

   logic in_burst;
   logic cap_hit;
   logic last_beat;
   logic fire;

   assign in_burst  = (state == BURST);
   assign cap_hit   = (count == CNT_LAST);
   assign last_beat = i_last[grant] | cap_hit;

   // The beat is driven straight from the granted slot's head. It stays stable
   // under a downstream stall because the head is only replaced by a pop.
   assign o_valid = in_burst & ready_slot[grant];
   assign fire    = o_valid & i_out_ready;
   assign o_data  = in_burst ? data_slot[grant] : '0;
   assign o_tid   = in_burst ? grant : '0;
   assign o_last  = in_burst & last_beat;
   assign o_busy  = in_burst;
   assign o_err   = err;

   // NOTE: o_pop gets a full default before the conditional bit set, so every
   // path assigns it and no latch is inferred.
   always_comb begin
      o_pop = '0;
      if (fire) o_pop[grant] = 1'b1;
   end

   // NOTE: all state below is updated with non-blocking assignments so that
   // every branch sees the pre-edge values of state, grant and count.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= IDLE;
         grant <= '0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // i_sel is only meaningful while some slot is ready.
               if (|i_ready) begin
                  grant <= i_sel;
                  count <= '0;
                  state <= BURST;
               end
            end
            BURST: begin
               // Ready slots other than the grant are ignored until the burst
               // ends. If the granted slot goes empty, the grant is held.
               if (fire) begin
                  count <= count + CNT_ONE;
                  if (last_beat) state <= IDLE;
                  if (cap_hit && !i_last[grant]) err <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trid_burst_drain.sv
// -----------------------------------------------------------------------------
// tb_trid_burst_drain
//
// Directed bench for trid_burst_drain, built with MAX_BEATS=4 so that the
// forced-termination path is reached with short bursts. Inputs change 2 time
// units after each rising edge. Outputs are sampled 1 unit later, well before
// the next edge.
// -----------------------------------------------------------------------------
module tb_trid_burst_drain;

   localparam int TRIDNUM   = 16;
   localparam int TRIDBIT   = 4;
   localparam int DATA_W    = 64;
   localparam int MAX_BEATS = 4;

   logic                      clk;
   logic                      rstn;
   logic [TRIDNUM-1:0]        ready;
   logic [TRIDBIT-1:0]        sel;
   logic [TRIDNUM*DATA_W-1:0] data;
   logic [TRIDNUM-1:0]        last;
   logic [TRIDNUM-1:0]        pop;
   logic                      valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         odata;
   logic [TRIDBIT-1:0]        tid;
   logic                      olast;
   logic                      busy;
   logic                      err;

   int checks = 0;
   int errors = 0;

   trid_burst_drain #(
      .TRIDNUM  (TRIDNUM),
      .TRIDBIT  (TRIDBIT),
      .DATA_W   (DATA_W),
      .MAX_BEATS(MAX_BEATS)
   ) dut (
      .i_clk      (clk),
      .i_rstn     (rstn),
      .i_ready    (ready),
      .i_sel      (sel),
      .i_data     (data),
      .i_last     (last),
      .o_pop      (pop),
      .o_valid    (valid),
      .i_out_ready(out_ready),
      .o_data     (odata),
      .o_tid      (tid),
      .o_last     (olast),
      .o_busy     (busy),
      .o_err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 2 units after the next rising edge (input drive point).
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Load the head beat of slot s.
   task automatic set_beat(input int s, input logic [63:0] d, input logic l);
      data[s*DATA_W +: DATA_W] = d;
      last[s] = l;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".valid"}, 64'(valid), 64'd0);
      check({tag, ".busy"},  64'(busy),  64'd0);
      check({tag, ".pop"},   64'(pop),   64'd0);
   endtask

   task automatic check_beat(input string tag, input logic [63:0] d, input int t,
                             input logic l, input logic [15:0] p);
      check({tag, ".valid"}, 64'(valid), 64'd1);
      check({tag, ".busy"},  64'(busy),  64'd1);
      check({tag, ".data"},  odata,      d);
      check({tag, ".tid"},   64'(tid),   64'(t));
      check({tag, ".last"},  64'(olast), 64'(l));
      check({tag, ".pop"},   64'(pop),   64'(p));
   endtask

   initial begin
      rstn      = 1'b0;
      ready     = '0;
      sel       = '0;
      data      = '0;
      last      = '0;
      out_ready = 1'b0;

      // ---------------- reset state ----------------
      #1;
      check("rst.valid", 64'(valid), 64'd0);
      check("rst.pop",   64'(pop),   64'd0);
      check("rst.data",  odata,      64'd0);
      check("rst.tid",   64'(tid),   64'd0);
      check("rst.last",  64'(olast), 64'd0);
      check("rst.busy",  64'(busy),  64'd0);
      check("rst.err",   64'(err),   64'd0);
      tick();
      tick();
      rstn = 1'b1;

      // ---------------- no ready for 10 cycles ----------------
      for (int i = 0; i < 10; i++) begin
         tick();
         #1 check_idle("quiet");
      end

      // ---------------- slot 3, 4-beat burst ----------------
      tick();
      ready = 16'h1000; sel = 4'd3; out_ready = 1'b1;
      set_beat(3, 64'hD0D0_0000_0000_0000, 1'b0);
      #1 check_idle("s3.grant");
      for (int b = 0; b < 4; b++) begin
         tick();
         set_beat(3, 64'hD0D0_0000_0000_0000 + 64'(b), (b == 3));
         #1 check_beat($sformatf("s3.b%0d", b), 64'hD0D0_0000_0000_0000 + 64'(b),
                       3, (b == 3), 16'h0008);
      end
      tick();
      ready = '0; last = '0;
      #1 check_idle("s3.after");
      check("s3.err", 64'(err), 64'd0);

      // ---------------- slot 7 burst, slot 0 arrives mid-burst ----------------
      tick();
      ready = 16'h0100; sel = 4'd7;
      set_beat(7, 64'hE7E7_0000_0000_0000, 1'b0);
      #1 check_idle("s7.grant");
      for (int b = 0; b < 4; b++) begin
         tick();
         set_beat(7, 64'hE7E7_0000_0000_0000 + 64'(b), (b == 3));
         if (b >= 2) begin
            ready = 16'h8100; sel = 4'd0;
            set_beat(0, 64'hF0F0_0000_0000_0001, 1'b1);
         end
         #1 check_beat($sformatf("s7.b%0d", b), 64'hE7E7_0000_0000_0000 + 64'(b),
                       7, (b == 3), 16'h0080);
      end
      // Slot 7 drained: the mandatory IDLE cycle re-arbitrates to slot 0.
      tick();
      ready = 16'h8000; last[7] = 1'b0;
      #1 check_idle("s0.gap");
      tick();
      #1 check_beat("s0.single", 64'hF0F0_0000_0000_0001, 0, 1'b1, 16'h0001);
      tick();
      ready = '0; last = '0;
      #1 check_idle("s0.after");

      // ---------------- slot 5, downstream stall on beat 1 ----------------
      tick();
      ready = 16'h0400; sel = 4'd5;
      set_beat(5, 64'h5555_0000_0000_0000, 1'b0);
      #1 check_idle("s5.grant");
      tick();
      #1 check_beat("s5.b0", 64'h5555_0000_0000_0000, 5, 1'b0, 16'h0020);
      tick();
      set_beat(5, 64'h5555_0000_0000_0001, 1'b1);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1 check_beat($sformatf("s5.stall%0d", i), 64'h5555_0000_0000_0001, 5, 1'b1, 16'h0000);
         tick();
      end
      out_ready = 1'b1;
      #1 check_beat("s5.b1", 64'h5555_0000_0000_0001, 5, 1'b1, 16'h0020);
      tick();
      ready = '0; last = '0;
      #1 check_idle("s5.after");

      // ---------------- slot 2, 6 beats without i_last ----------------
      tick();
      ready = 16'h2000; sel = 4'd2;
      set_beat(2, 64'h2222_0000_0000_0000, 1'b0);
      #1 check_idle("s2.grant");
      for (int b = 0; b < 4; b++) begin
         tick();
         set_beat(2, 64'h2222_0000_0000_0000 + 64'(b), 1'b0);
         #1 check_beat($sformatf("s2.b%0d", b), 64'h2222_0000_0000_0000 + 64'(b),
                       2, (b == 3), 16'h0004);
         check($sformatf("s2.err_b%0d", b), 64'(err), 64'd0);
      end
      // Forced termination: IDLE with the sticky error set, then a new burst.
      tick();
      set_beat(2, 64'h2222_0000_0000_0004, 1'b0);
      #1 check_idle("s2.forced");
      check("s2.err_set", 64'(err), 64'd1);
      for (int b = 4; b < 6; b++) begin
         tick();
         set_beat(2, 64'h2222_0000_0000_0000 + 64'(b), 1'b0);
         #1 check_beat($sformatf("s2.b%0d", b), 64'h2222_0000_0000_0000 + 64'(b),
                       2, 1'b0, 16'h0004);
      end
      // Slot 2 runs dry with no last beat: the grant is held.
      tick();
      ready = '0;
      #1 check("s2.hold.busy",  64'(busy),  64'd1);
      check("s2.hold.valid", 64'(valid), 64'd0);
      check("s2.hold.pop",   64'(pop),   64'd0);
      check("s2.hold.err",   64'(err),   64'd1);
      tick();
      #1 check("s2.hold2.busy", 64'(busy), 64'd1);

      // Reset is the only way to clear the sticky error.
      rstn = 1'b0;
      #1 check("s2.rst.err", 64'(err), 64'd0);
      check("s2.rst.busy", 64'(busy), 64'd0);
      tick();
      rstn = 1'b1;

      // ---------------- slot 9, async reset at beat 2 ----------------
      tick();
      ready = 16'h0040; sel = 4'd9;
      set_beat(9, 64'h9999_0000_0000_0000, 1'b0);
      #1 check_idle("s9.grant");
      for (int b = 0; b < 3; b++) begin
         tick();
         set_beat(9, 64'h9999_0000_0000_0000 + 64'(b), 1'b0);
         #1 check_beat($sformatf("s9.b%0d", b), 64'h9999_0000_0000_0000 + 64'(b),
                       9, 1'b0, 16'h0200);
      end
      #1 rstn = 1'b0;
      #1;
      check("s9.rst.valid", 64'(valid), 64'd0);
      check("s9.rst.pop",   64'(pop),   64'd0);
      check("s9.rst.data",  odata,      64'd0);
      check("s9.rst.tid",   64'(tid),   64'd0);
      check("s9.rst.last",  64'(olast), 64'd0);
      check("s9.rst.busy",  64'(busy),  64'd0);
      check("s9.rst.err",   64'(err),   64'd0);
      tick();
      rstn = 1'b1;
      // Beat 2 was never popped, so it is still the head after re-grant.
      set_beat(9, 64'h9999_0000_0000_0002, 1'b1);
      #1 check_idle("s9.regrant");
      check("s9.regrant.err", 64'(err), 64'd0);
      tick();
      #1 check_beat("s9.b2again", 64'h9999_0000_0000_0002, 9, 1'b1, 16'h0200);
      tick();
      ready = '0; last = '0;
      #1 check_idle("s9.after");
      check("s9.after.err", 64'(err), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
